// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
// Requests and responses each use a valid/ready handshake.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM with RISC-V load/store semantics behind a valid/ready
// handshake; every access takes 1+WAIT_CYCLES edges from accept to response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clock,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // ACC is the single edge on which the RAM is read/written and the response registered.
  typedef enum logic [1:0] {IDLE, WAIT, ACC, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic          acc_err;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   lane_data;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

  assign accept = bus.req_valid && bus.req_ready;
  assign commit = (state_q == ACC);
  assign idx    = addr_q[AW+1:2];

  always_comb begin
    acc_err = (size_q == 2'b11)
           || (size_q == 2'b01 && addr_q[0])
           || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
           || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (size_q)
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    rd_word  = mem[idx];
    byte_sel = 8'(rd_word >> {addr_q[1:0], 3'b000});
    half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   load_val = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
      2'b01:   load_val = {{16{half_sel[15] & ~uns_q}}, half_sel};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACC;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACC;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_error_d = acc_err;
        rsp_rdata_d = (acc_err || wr_q) ? 32'd0 : load_val;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_error_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Reset forces state out of ACC asynchronously, so an uncommitted store is dropped.
  always_ff @(posedge clock) begin
    if (commit && wr_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end
endmodule
